// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared types, constants and address helpers for the ID-stage hazard/next-PC control
// Provides the mult/div FSM state enum, the hard-wired zero register number,
// default widths and the branch/jump address helpers.
package pipe_ctrl_pkg;
    typedef enum logic {MD_IDLE, MD_RUN} md_state_e;
    localparam int unsigned REG_ZERO = 0;
    localparam int DEF_AW = 32;
    localparam int DEF_RAW = 5;
    localparam int DEF_DW = 32;
    // Wide enough for any AW up to 64; callers truncate to AW.
    function automatic logic [63:0] sign_ext16(input logic [15:0] imm);
        return {{48{imm[15]}}, imm};
    endfunction
    // Low 28 bits of a j/jal target; the upper PC bits come from PC+4.
    function automatic logic [27:0] jump_addr(input logic [25:0] target);
        return {target, 2'b00};
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID/EX/MEM status inputs and stall/flush/redirect outputs of the hazard controller
// slave: used by pipe_hazard_ctrl (reads pipeline state, drives control)
// master: used by the pipeline side (drives pipeline state, reads control)
interface pipe_hazard_ctrl_if #(
    parameter int AW  = pipe_ctrl_pkg::DEF_AW,
    parameter int RAW = pipe_ctrl_pkg::DEF_RAW,
    parameter int DW  = pipe_ctrl_pkg::DEF_DW
) ();
    logic           id_valid;
    logic [RAW-1:0] id_rs, id_rt;
    logic           id_use_rs, id_use_rt;
    logic           id_branch, id_bne, id_jump, id_jr;
    logic           id_md_start, id_md_read;
    logic [AW-1:0]  id_pc4;
    logic [15:0]    id_imm16;
    logic [25:0]    id_target;
    logic [DW-1:0]  id_bus_a, id_bus_b;
    logic           ex_regwr, ex_memtoreg;
    logic [RAW-1:0] ex_rd;
    logic           mem_memtoreg;
    logic [RAW-1:0] mem_rd;
    logic           pc_stall, ifid_stall, ifid_flush, idex_bubble, redirect;
    logic [AW-1:0]  npc;
    logic           md_busy;

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_bne, id_jump, id_jr,
               id_md_start, id_md_read, id_pc4, id_imm16, id_target, id_bus_a, id_bus_b,
               ex_regwr, ex_memtoreg, ex_rd, mem_memtoreg, mem_rd,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble, redirect, npc, md_busy
    );
    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_bne, id_jump, id_jr,
               id_md_start, id_md_read, id_pc4, id_imm16, id_target, id_bus_a, id_bus_b,
               ex_regwr, ex_memtoreg, ex_rd, mem_memtoreg, mem_rd,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble, redirect, npc, md_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hz_md_timer.sv
// hz_md_timer: mult/div busy timer, MD_LAT busy cycles after an accepted start
// Ports: clk, rst_n (async active-low), start (accepted issue), busy (registered run state)
module hz_md_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);
    localparam int CW = $clog2(MD_LAT + 1);

    md_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = (state_q == MD_IDLE) ? (start ? MD_RUN : MD_IDLE)
                                       : ((cnt_q == CW'(1)) ? MD_IDLE : MD_RUN);
        cnt_d   = (state_q == MD_IDLE) ? (start ? CW'(MD_LAT) : cnt_q) : cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == MD_RUN);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ID-stage hazard detection and beq/bne/j/jal/jr next-PC control
// Ports: clk, rst_n (async active-low), bus (pipe_hazard_ctrl_if.slave).
// Optional HAZ_PERF_CNT_EN adds saturating perf_stall_cnt/perf_flush_cnt/perf_md_cnt outputs.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int RAW    = DEF_RAW,
    parameter int MD_LAT = 4,
    parameter int DW     = DEF_DW
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_hazard_ctrl_if.slave   bus
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_flush_cnt,
    output logic [31:0]         perf_md_cnt
`endif
);
    logic load_use, br_haz, md_haz, stall, take, md_busy, md_start;
    logic dep_ex, dep_mem;
    logic [AW-1:0] npc_c;

    function automatic logic dep(input logic [RAW-1:0] r, input logic [RAW-1:0] d, input logic u);
        return u && (r != RAW'(REG_ZERO)) && (r == d);
    endfunction

    always_comb begin
        dep_ex   = dep(bus.id_rs, bus.ex_rd, bus.id_use_rs) | dep(bus.id_rt, bus.ex_rd, bus.id_use_rt);
        dep_mem  = dep(bus.id_rs, bus.mem_rd, bus.id_use_rs) | dep(bus.id_rt, bus.mem_rd, bus.id_use_rt);
        load_use = bus.id_valid & bus.ex_memtoreg & dep_ex;
        // ID-resolved branches compare before EX/MEM results can be forwarded.
        br_haz   = bus.id_valid & (bus.id_branch | bus.id_jr) &
                   ((bus.ex_regwr & dep_ex) | (bus.mem_memtoreg & dep_mem));
        md_haz   = bus.id_valid & (bus.id_md_read | bus.id_md_start) & md_busy;
        stall    = load_use | br_haz | md_haz;
        take     = bus.id_valid & ~stall &
                   (bus.id_jump | bus.id_jr | (bus.id_branch & ((bus.id_bus_a == bus.id_bus_b) ^ bus.id_bne)));
        npc_c    = !bus.id_valid ? bus.id_pc4 :
                   bus.id_jr     ? AW'(bus.id_bus_a) :
                   bus.id_jump   ? (bus.id_pc4 & ~AW'(28'hFFF_FFFF)) | AW'(jump_addr(bus.id_target)) :
                   bus.id_branch ? bus.id_pc4 + AW'(sign_ext16(bus.id_imm16) << 2) :
                                   bus.id_pc4;
        bus.pc_stall    = rst_n & stall;
        bus.ifid_stall  = rst_n & stall;
        bus.idex_bubble = rst_n & stall;
        bus.ifid_flush  = rst_n & take;
        bus.redirect    = rst_n & take;
        bus.npc         = rst_n ? npc_c : '0;
        bus.md_busy     = md_busy;
    end

    assign md_start = bus.id_md_start & ~stall;

    hz_md_timer #(.MD_LAT(MD_LAT)) u_md_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .busy  (md_busy)
    );

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, md_cnt_q, md_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(stall & ~&stall_cnt_q);
        flush_cnt_d = flush_cnt_q + 32'(take & ~&flush_cnt_q);
        md_cnt_d    = md_cnt_q + 32'(md_haz & ~&md_cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            md_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            md_cnt_q    <= md_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
    assign perf_md_cnt    = md_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic clk = 0;
    logic rst_n;
    int checks = 0;
    int failures = 0;

    pipe_hazard_ctrl_if bus ();
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_md_cnt;
`endif

    pipe_hazard_ctrl #(.AW(32), .RAW(5), .MD_LAT(4), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_md_cnt    (perf_md_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic expect_o(input string t, input logic s, input logic f, input logic [31:0] n);
        chk({t, ".pc_stall"}, 64'(bus.pc_stall), 64'(s));
        chk({t, ".ifid_stall"}, 64'(bus.ifid_stall), 64'(s));
        chk({t, ".idex_bubble"}, 64'(bus.idex_bubble), 64'(s));
        chk({t, ".ifid_flush"}, 64'(bus.ifid_flush), 64'(f));
        chk({t, ".redirect"}, 64'(bus.redirect), 64'(f));
        chk({t, ".npc"}, 64'(bus.npc), 64'(n));
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0; bus.id_use_rt = 0;
        bus.id_branch = 0; bus.id_bne = 0; bus.id_jump = 0; bus.id_jr = 0;
        bus.id_md_start = 0; bus.id_md_read = 0; bus.id_pc4 = 0; bus.id_imm16 = 0;
        bus.id_target = 0; bus.id_bus_a = 0; bus.id_bus_b = 0;
        bus.ex_regwr = 0; bus.ex_memtoreg = 0; bus.ex_rd = 0; bus.mem_memtoreg = 0; bus.mem_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        bus.id_valid = 1; bus.id_jump = 1; bus.id_pc4 = 32'h1234;
        #2 expect_o("rst", 0, 0, 32'h0);
        chk("rst.md_busy", 64'(bus.md_busy), 0);
        tick(); tick();
        rst_n = 1;
        idle(); bus.id_valid = 1; bus.id_pc4 = 32'h100;
        #2 expect_o("nop", 0, 0, 32'h100);

        // lw $2 in EX, add reads $2
        tick(); idle(); bus.id_valid = 1; bus.id_pc4 = 32'h104;
        bus.id_rs = 2; bus.id_use_rs = 1; bus.ex_regwr = 1; bus.ex_memtoreg = 1; bus.ex_rd = 2;
        #2 expect_o("lu", 1, 0, 32'h104);
        tick(); bus.ex_regwr = 0; bus.ex_memtoreg = 0; bus.ex_rd = 0;
        #2 expect_o("lu_clear", 0, 0, 32'h104);
        tick(); bus.ex_regwr = 1; bus.ex_memtoreg = 1; bus.ex_rd = 0; bus.id_rs = 0;
        #2 expect_o("lu_r0", 0, 0, 32'h104);
        tick(); bus.ex_rd = 2; bus.id_rs = 2; bus.id_use_rs = 0;
        #2 expect_o("lu_nouse", 0, 0, 32'h104);
        tick(); bus.id_use_rs = 0; bus.id_rt = 2; bus.id_use_rt = 1;
        #2 expect_o("lu_rt", 1, 0, 32'h104);
        tick(); bus.ex_memtoreg = 0;
        #2 expect_o("alu_fwd", 0, 0, 32'h104);

        // beq $3 behind lw $3: stalled in EX then MEM, then taken
        tick(); idle(); bus.id_valid = 1; bus.id_pc4 = 32'h100; bus.id_imm16 = 16'h0004;
        bus.id_branch = 1; bus.id_rs = 3; bus.id_use_rs = 1;
        bus.ex_regwr = 1; bus.ex_memtoreg = 1; bus.ex_rd = 3;
        #2 expect_o("br_lw_ex", 1, 0, 32'h110);
        tick(); bus.ex_regwr = 0; bus.ex_memtoreg = 0; bus.ex_rd = 0; bus.mem_memtoreg = 1; bus.mem_rd = 3;
        #2 expect_o("br_lw_mem", 1, 0, 32'h110);
        tick(); bus.mem_memtoreg = 0; bus.mem_rd = 0; bus.id_bus_a = 5; bus.id_bus_b = 5;
        #2 expect_o("beq_taken", 0, 1, 32'h110);
        tick(); bus.ex_regwr = 1; bus.ex_rd = 3;
        #2 expect_o("br_alu_ex", 1, 0, 32'h110);
        tick(); bus.ex_regwr = 0; bus.ex_rd = 0; bus.id_bus_b = 6;
        #2 expect_o("beq_nt", 0, 0, 32'h110);

        // bne backward offsets and wrap
        tick(); idle(); bus.id_valid = 1; bus.id_branch = 1; bus.id_bne = 1;
        bus.id_pc4 = 32'h4; bus.id_imm16 = 16'hFFFF; bus.id_bus_a = 1; bus.id_bus_b = 2;
        #2 expect_o("bne_taken", 0, 1, 32'h0);
        tick(); bus.id_bus_b = 1;
        #2 expect_o("bne_nt", 0, 0, 32'h0);
        tick(); bus.id_bne = 0; bus.id_pc4 = 32'h0;
        #2 expect_o("beq_wrap", 0, 1, 32'hFFFF_FFFC);

        // j / jr
        tick(); idle(); bus.id_valid = 1; bus.id_jump = 1; bus.id_target = 26'h0000100; bus.id_pc4 = 32'hA000_0000;
        #2 expect_o("j", 0, 1, 32'hA000_0400);
        tick(); bus.id_jr = 1; bus.id_bus_a = 32'h0040_0020;
        #2 expect_o("jr_prio", 0, 1, 32'h0040_0020);
        tick(); bus.id_jump = 0; bus.id_rs = 4; bus.id_use_rs = 1; bus.ex_regwr = 1; bus.ex_rd = 4;
        #2 expect_o("jr_haz", 1, 0, 32'h0040_0020);
        tick(); bus.id_valid = 0;
        #2 expect_o("invalid", 0, 0, 32'hA000_0000);

        // mult then mflo: 4 busy cycles
        tick(); idle(); bus.id_valid = 1; bus.id_md_start = 1; bus.id_pc4 = 32'h200;
        #2 expect_o("md_issue", 0, 0, 32'h200);
        chk("md_issue.busy", 64'(bus.md_busy), 0);
        tick(); bus.id_md_start = 0; bus.id_md_read = 1; bus.id_pc4 = 32'h204;
        for (int i = 0; i < 4; i++) begin
            #2 expect_o($sformatf("md_wait%0d", i), 1, 0, 32'h204);
            chk($sformatf("md_wait%0d.busy", i), 64'(bus.md_busy), 1);
            tick();
        end
        #2 expect_o("md_done", 0, 0, 32'h204);
        chk("md_done.busy", 64'(bus.md_busy), 0);

        // second start while busy, then reset mid-run
        tick(); bus.id_md_read = 0; bus.id_md_start = 1;
        tick();
        #2 expect_o("md_restart", 1, 0, 32'h204);
        tick();
        rst_n = 0;
        #1 chk("md_rst.busy", 64'(bus.md_busy), 0);
        expect_o("md_rst", 0, 0, 32'h0);
        tick();
        rst_n = 1; bus.id_md_start = 0; bus.id_md_read = 1;
        #2 expect_o("md_after_rst", 0, 0, 32'h204);
        chk("md_after_rst.busy", 64'(bus.md_busy), 0);

`ifdef HAZ_PERF_CNT_EN
        tick(); bus.id_md_read = 0; bus.id_md_start = 1;
        tick(); bus.id_md_start = 0; bus.id_md_read = 1;
        repeat (5) tick();
        bus.id_md_read = 0; bus.id_jump = 1;
        tick(); idle();
        #2 chk("perf_stall", 64'(perf_stall_cnt), 4);
        chk("perf_flush", 64'(perf_flush_cnt), 1);
        chk("perf_md", 64'(perf_md_cnt), 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
